riscv_crypto_ssm3_msg_sched: RTL and testbench
==============================================

# riscv_crypto_ssm3_msg_sched

Sequential SM3 message-expansion scheduler built around the SSM3 P1 permutation (x ^ rol(x,15) ^ rol(x,23)). It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready stream. It then emits the expanded pairs W_j and W'_j = W_j ^ W_(j+4), one pair per cycle, to the SM3 compression round logic. It sits between the message buffer and the compression datapath, and replaces per-round software calls of ssm3.p1 during message expansion.

## Interface
- ROUNDS, 64, number of (W_j, W'_j) pairs emitted per block; legal range 1..64.
- g_clk  in  1  clock; all state updates on the rising edge.
- g_resetn  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous abort; returns the block to LOAD.
- in_valid  in  1  message word valid.
- in_ready  out  1  block accepts a message word (LOAD state).
- in_data  in  32  message word; W0 arrives first, big-endian word order already applied.
- out_valid  out  1  expanded pair valid.
- out_ready  in  1  consumer accepts the pair.
- out_w  out  32  W_j.
- out_wp  out  32  W'_j.
- out_idx  out  6  j of the current pair.
- out_last  out  1  high with the pair where j == ROUNDS-1.
- busy  out  1  high in RUN, or while the output stage holds data.

## Operation
- State: 16x32 window w[0..15] holding W_j..W_(j+15), a 4-bit load counter `lcnt`, a 6-bit round counter `ridx`, and FSM {LOAD, RUN}.
- LOAD:
  - in_ready=1.
  - On an in handshake: shift the window down one slot (w[k] <= w[k+1]), set w[15] <= in_data, and increment lcnt.
  - On the handshake with lcnt==15: lcnt <= 0, ridx <= 0, go to RUN. W0 then sits in w[0].
- RUN:
  - in_ready=0.
  - Pair source: W_j = w[0]; W'_j = w[0]^w[4].
  - New word: Wn = P1(w[0]^w[7]^rol(w[13],15)) ^ rol(w[3],7) ^ w[10]. All rotates are 32-bit modular.
  - On a pair advance, the window shifts down with w[15] <= Wn, and ridx increments.
  - The advance with ridx==ROUNDS-1 returns to LOAD with ridx <= 0.
  - Words generated beyond W67 are computed but never emitted.
- flush:
  - Takes priority over every handshake in the same cycle.
  - Resets state to LOAD, and lcnt and ridx to 0.
  - Drops any pending output, so out_valid is 0 the next cycle.
  - Does not clear the window.
- A block can be reloaded immediately after out_last is consumed. No idle cycle is required beyond the LOAD state itself.
- Reset values: state LOAD, lcnt 0, ridx 0, window all zero, in_ready 1, out_valid 0, out_w/out_wp/out_idx 0, out_last 0, busy 0.

## Timing
- Input: a word is consumed on any cycle with in_valid&in_ready; LOAD takes at least 16 cycles. in_valid in RUN is ignored and nothing is consumed.
- Output handshake: the pair transfers when out_valid&out_ready. While stalled, out_valid, out_w, out_wp, out_idx and out_last hold stable. out_valid never drops without a transfer, except on flush or reset.
- Without the Configuration macro:
  - out_valid is high exactly in RUN, and out_* are combinational from the window.
  - The first pair is valid in the cycle after the 16th input handshake.
  - Sustained throughput is 1 pair/cycle.
- Minimum block time is 16 + ROUNDS cycles.
- Asynchronous reset mid-block discards all progress; the next block starts from lcnt 0.

## Configuration
- RISCV_CRYPTO_SSM3_SCHED_OREG_EN defined: out_w, out_wp, out_idx, out_last and out_valid are driven from a single output register stage.
  - The stage loads from the window when (!out_valid || out_ready) in RUN, and the window advances on that load.
  - The last load returns the FSM to LOAD while the stage still holds the final pair. busy stays high until that pair transfers.
  - Adds one cycle of latency: the first pair is valid 2 cycles after the 16th input handshake.
  - Throughput remains 1 pair/cycle. The registers reset to 0.
- Not defined: the combinational output path described in Timing.

## Test plan
- Reset: assert g_resetn=0 mid-RUN -> next cycle in_ready=1, out_valid=0, busy=0; a fresh 16-word load then produces idx 0 correctly.
- All-zero block, out_ready=1 -> 64 pairs, all out_w=0 and out_wp=0; out_idx runs 0..63; out_last only at idx 63; exactly 80 cycles from the first in handshake.
- Block W0=0x00000001, rest 0 -> idx0 gives out_w=0x00000001 and out_wp=0x00000001. Internal W16=0x00808001 appears as out_w at idx 16. All pairs match a C golden model, and the GB/T 32905 "abc" block matches the same model.
- Random out_ready back-pressure (50%) on the "abc" block -> outputs hold stable while stalled, with no dropped or duplicated idx.
- flush asserted at lcnt=9, and separately at ridx=30 -> out_valid=0 next cycle, in_ready=1; a reloaded block's outputs are unaffected.
- ROUNDS=4 -> exactly idx 0..3, out_last at idx 3; a back-to-back second block is accepted the following cycle.

Source files
------------

// File: rtl/riscv_crypto_ssm3_msg_sched.sv
// SM3 message-expansion scheduler: loads 16 words, then streams (W_j, W_j ^ W_(j+4)) pairs.
// Optional output register stage: define RISCV_CRYPTO_SSM3_SCHED_OREG_EN.
module riscv_crypto_ssm3_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_w,
    output logic [31:0] out_wp,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [3:0]  lcnt_q, lcnt_d;
    logic [5:0]  ridx_q, ridx_d;
    logic [31:0] wn;
    logic        last_rnd;
    logic        adv;

    function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned sh);
        return (x << sh) | (x >> (32 - sh));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol32(x, 15) ^ rol32(x, 23);
    endfunction

    assign wn       = p1(win_q[0] ^ win_q[7] ^ rol32(win_q[13], 15)) ^ rol32(win_q[3], 7) ^ win_q[10];
    assign last_rnd = (ridx_q == 6'(ROUNDS - 1));
    assign in_ready = (state_q == LOAD);

    // Window / FSM next state; flush wins over both handshakes but leaves the window alone
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        lcnt_d  = lcnt_q;
        ridx_d  = ridx_q;
        if (flush) begin
            state_d = LOAD;
            lcnt_d  = '0;
            ridx_d  = '0;
        end else if (state_q == LOAD && in_valid) begin
            for (int k = 0; k < 15; k++) win_d[k] = win_q[k+1];
            win_d[15] = in_data;
            lcnt_d    = lcnt_q + 4'd1;
            if (lcnt_q == 4'd15) begin
                lcnt_d  = '0;
                ridx_d  = '0;
                state_d = RUN;
            end
        end else if (adv) begin
            for (int k = 0; k < 15; k++) win_d[k] = win_q[k+1];
            win_d[15] = wn;
            ridx_d    = ridx_q + 6'd1;
            if (last_rnd) begin
                ridx_d  = '0;
                state_d = LOAD;
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= LOAD;
            lcnt_q  <= '0;
            ridx_q  <= '0;
            for (int k = 0; k < 16; k++) win_q[k] <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            ridx_q  <= ridx_d;
            win_q   <= win_d;
        end
    end

`ifdef RISCV_CRYPTO_SSM3_SCHED_OREG_EN
    logic        oval_q;
    logic [31:0] ow_q, owp_q;
    logic [5:0]  oidx_q;
    logic        olast_q;

    // The window advances exactly when the output stage takes a new pair
    assign adv = (state_q == RUN) && (!oval_q || out_ready);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            oval_q  <= 1'b0;
            ow_q    <= '0;
            owp_q   <= '0;
            oidx_q  <= '0;
            olast_q <= 1'b0;
        end else if (flush) begin
            oval_q <= 1'b0;
        end else if (adv) begin
            oval_q  <= 1'b1;
            ow_q    <= win_q[0];
            owp_q   <= win_q[0] ^ win_q[4];
            oidx_q  <= ridx_q;
            olast_q <= last_rnd;
        end else if (out_ready) begin
            oval_q <= 1'b0;
        end
    end

    assign out_valid = oval_q;
    assign out_w     = ow_q;
    assign out_wp    = owp_q;
    assign out_idx   = oidx_q;
    assign out_last  = olast_q;
    assign busy      = (state_q == RUN) || oval_q;
`else
    assign adv       = (state_q == RUN) && out_ready;
    assign out_valid = (state_q == RUN);
    assign out_w     = win_q[0];
    assign out_wp    = win_q[0] ^ win_q[4];
    assign out_idx   = ridx_q;
    assign out_last  = (state_q == RUN) && last_rnd;
    assign busy      = (state_q == RUN);
`endif

endmodule

// File: tb/tb_riscv_crypto_ssm3_msg_sched.sv
// Bench for riscv_crypto_ssm3_msg_sched: scoreboard of expected pairs from a standalone SM3 expansion model.
module tb_riscv_crypto_ssm3_msg_sched;

    logic        g_clk = 1'b0;
    logic        g_resetn, flush, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [31:0] in_data, out_w, out_wp;
    logic [5:0]  out_idx;

    logic        flush4, in4_valid, in4_ready, out4_valid, out4_ready, out4_last, busy4;
    logic [31:0] in4_data, out4_w, out4_wp;
    logic [5:0]  out4_idx;

    riscv_crypto_ssm3_msg_sched #(.ROUNDS(64)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w), .out_wp(out_wp),
        .out_idx(out_idx), .out_last(out_last), .busy(busy));

    riscv_crypto_ssm3_msg_sched #(.ROUNDS(4)) dut4 (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush4), .in_valid(in4_valid), .in_ready(in4_ready),
        .in_data(in4_data), .out_valid(out4_valid), .out_ready(out4_ready), .out_w(out4_w), .out_wp(out4_wp),
        .out_idx(out4_idx), .out_last(out4_last), .busy(busy4));

    always #5 g_clk = ~g_clk;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] wp;
        logic [5:0]  idx;
        logic        last;
    } pair_t;

`ifdef RISCV_CRYPTO_SSM3_SCHED_OREG_EN
    localparam int OLAT = 1;
`else
    localparam int OLAT = 0;
`endif

    pair_t       q[$];
    pair_t       q4[$];
    logic [31:0] feed4[$];
    logic [31:0] blk [16];
    logic [31:0] wx [68];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ntx = 0;
    int          first_hs_cyc = 0;
    int          last_tx_cyc = 0;
    int          hs4 = 0;
    int          hs17_cyc = -1;
    int          last4_cyc = -1;
    bit          rand_rdy = 0;
    bit          stall_v = 0;
    pair_t       stall_p;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] perm1(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    // Textbook SM3 expansion: W[j] from W[j-16], W[j-13], W[j-9], W[j-6], W[j-3]
    function automatic void build();
        for (int j = 0; j < 16; j++) wx[j] = blk[j];
        for (int j = 16; j < 68; j++)
            wx[j] = perm1(wx[j-16] ^ wx[j-9] ^ rol(wx[j-3], 15)) ^ rol(wx[j-13], 7) ^ wx[j-6];
    endfunction

    function automatic void push_exp(input int rounds, input bit to4);
        pair_t e;
        for (int j = 0; j < rounds; j++) begin
            e.w    = wx[j];
            e.wp   = wx[j] ^ wx[j+4];
            e.idx  = 6'(j);
            e.last = (j == rounds - 1);
            if (to4) q4.push_back(e);
            else q.push_back(e);
        end
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        pair_t p;
        pair_t e;
        @(negedge g_clk);
        cyc++;
        p = {out_w, out_wp, out_idx, out_last};
        if (stall_v && !flush) begin
            chk("hold_valid", 128'(out_valid), 128'(1'b1));
            chk("hold_data", 128'(p), 128'(stall_p));
        end
        stall_v = 0;
        if (out_valid && !flush) begin
            if (out_ready) begin
                if (q.size() == 0) chk("extra_pair", 128'(out_idx), 128'(7'h7f));
                else begin
                    e = q.pop_front();
                    chk("w", 128'(out_w), 128'(e.w));
                    chk("wp", 128'(out_wp), 128'(e.wp));
                    chk("idx", 128'(out_idx), 128'(e.idx));
                    chk("last", 128'(out_last), 128'(e.last));
                    ntx++;
                    if (out_last) last_tx_cyc = cyc;
                end
            end else begin
                stall_v = 1;
                stall_p = p;
            end
        end
        if (out4_valid && out4_ready) begin
            if (q4.size() == 0) chk("r4_extra_pair", 128'(out4_idx), 128'(7'h7f));
            else begin
                e = q4.pop_front();
                chk("r4_w", 128'(out4_w), 128'(e.w));
                chk("r4_wp", 128'(out4_wp), 128'(e.wp));
                chk("r4_idx", 128'(out4_idx), 128'(e.idx));
                chk("r4_last", 128'(out4_last), 128'(e.last));
                if (out4_last && last4_cyc < 0) last4_cyc = cyc;
            end
        end
        if (in4_valid && in4_ready && feed4.size() > 0) begin
            void'(feed4.pop_front());
            hs4++;
            if (hs4 == 17) hs17_cyc = cyc;
        end
        @(posedge g_clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        in4_valid = (feed4.size() > 0);
        in4_data  = (feed4.size() > 0) ? feed4[0] : 32'h0;
    endtask

    task automatic load(input int n);
        int  k;
        bit  done;
        for (int i = 0; i < n; i++) begin
            k = 0;
            done = 0;
            in_valid = 1'b1;
            in_data  = blk[i];
            while (!done && k < 20) begin
                done = in_ready;
                tick();
                k++;
                if (done && i == 0) first_hs_cyc = cyc;
            end
            if (!done) chk("load_timeout", 128'(i), 128'(16));
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (q.size() > 0 && k < budget) begin
            tick();
            k++;
        end
        if (q.size() > 0) chk("drain_timeout", 128'(q.size()), 128'(0));
    endtask

    task automatic run_tx(input int n);
        int target = ntx + n;
        int k = 0;
        while (ntx < target && k < 400) begin
            tick();
            k++;
        end
        if (ntx < target) chk("run_timeout", 128'(ntx), 128'(target));
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic abc_block();
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hbad0bad0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        q.delete();
        stall_v = 0;
        chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
        chk("flush_in_ready", 128'(in_ready), 128'(1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        g_resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        flush4 = 1'b0; in4_valid = 1'b0; in4_data = '0; out4_ready = 1'b1;
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_out", 128'({out_w, out_wp, out_idx, out_last}), 128'(0));
        tick();
        g_resetn = 1'b1;
        tick();

        // All-zero block, full-rate output, cycle-exact block time
        for (int i = 0; i < 16; i++) blk[i] = '0;
        build();
        push_exp(64, 0);
        load(16);
        if (OLAT == 1) begin
            chk("first_valid_oreg_early", 128'(out_valid), 128'(1'b0));
            tick();
        end
        chk("first_valid", 128'(out_valid), 128'(1'b1));
        drain(200);
        chk("block_cycles", 128'(last_tx_cyc - first_hs_cyc + 1), 128'(80 + OLAT));
        chk("busy_idle", 128'(busy), 128'(1'b0));

        // Single-bit block; in_valid junk during RUN must be ignored
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 32'h00000001;
        build();
        chk("model_w16", 128'(wx[16]), 128'(32'h00808001));
        push_exp(64, 0);
        load(16);
        in_valid = 1'b1;
        in_data  = 32'hdeadbeef;
        run_tx(60);
        in_valid = 1'b0;
        in_data  = '0;
        drain(50);

        // "abc" block under random back-pressure
        abc_block();
        build();
        push_exp(64, 0);
        rand_rdy = 1;
        load(16);
        drain(1000);
        rand_rdy = 0;
        out_ready = 1'b1;
        tick();

        // Flush part-way through LOAD, then a clean reload
        rand_block();
        load(9);
        do_flush();
        rand_block();
        build();
        push_exp(64, 0);
        load(16);
        drain(200);

        // Flush part-way through RUN, then a clean reload
        abc_block();
        build();
        push_exp(64, 0);
        load(16);
        run_tx(30);
        do_flush();
        rand_block();
        build();
        push_exp(64, 0);
        load(16);
        drain(200);

        // Asynchronous reset mid-RUN
        rand_block();
        build();
        push_exp(64, 0);
        load(16);
        run_tx(5);
        g_resetn = 1'b0;
        #2;
        chk("arst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("arst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("arst_busy", 128'(busy), 128'(1'b0));
        q.delete();
        stall_v = 0;
        tick();
        g_resetn = 1'b1;
        tick();
        abc_block();
        build();
        push_exp(64, 0);
        load(16);
        drain(200);

        // ROUNDS=4 instance: two blocks back to back
        abc_block();
        build();
        push_exp(4, 1);
        for (int i = 0; i < 16; i++) feed4.push_back(blk[i]);
        rand_block();
        build();
        push_exp(4, 1);
        for (int i = 0; i < 16; i++) feed4.push_back(blk[i]);
        in4_valid = 1'b1;
        in4_data  = feed4[0];
        for (int k = 0; k < 200 && q4.size() > 0; k++) tick();
        chk("r4_drained", 128'(q4.size()), 128'(0));
        for (int k = 0; k < 5; k++) tick();
        chk("r4_back_to_back", 128'(hs17_cyc - last4_cyc), 128'(1 - OLAT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
